rstctrl_linkseq: RTL and testbench

- PHY bring-up sequencer that sits directly around the PHY reset-detection stage.
- Issues the PHY sys_reset pulse and holds the detector in reset while that pulse is active.
- Consumes the detector's sticky rst_done/stat_good, qualifies live link status, then releases MAC and core resets in stages.
- Retries on timeout, re-sequences on link loss, and latches a fail flag after too many retries.

---
 rtl/rstctrl_linkseq.sv | 247 ++++++++++++++++++++++++
 tb/tb_rstctrl_linkseq.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/rstctrl_linkseq.sv
// PHY bring-up sequencer: pulses the PHY reset, waits for the detector's
// sticky done/good flags, qualifies live link status, then releases the MAC
// and core resets in stages. Retries on timeout, re-sequences on link loss
// and latches a fail flag once the retry allowance is used up.
module rstctrl_linkseq #(
  parameter int PHY_RST_CYC = 16,
  parameter int TIMEOUT_CYC = 1048576,
  parameter int STABLE_CYC  = 1024,
  parameter int STAGE_GAP   = 8,
  parameter int LOSS_CYC    = 64,
  parameter int MAX_RETRY   = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       restart,
  input  logic       rst_done,
  input  logic       stat_good,
  input  logic       stat_rx,
  input  logic       stat_tx,
  output logic       phy_sys_reset,
  output logic       mon_reset_,
  output logic       mac_reset_,
  output logic       core_reset_,
  output logic       link_up,
  output logic       fail,
  output logic [3:0] retry_cnt,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    ST_PHY_RST   = 3'd0,
    ST_WAIT_DONE = 3'd1,
    ST_WAIT_STAT = 3'd2,
    ST_STABLE    = 3'd3,
    ST_REL_MAC   = 3'd4,
    ST_REL_CORE  = 3'd5,
    ST_UP        = 3'd6,
    ST_FAIL      = 3'd7
  } state_t;

  // Timeout timer width covers the full window; the shared phase counter is
  // sized for the longest of the per-state counts it has to hold.
  localparam int TW      = $clog2(TIMEOUT_CYC + 1);
  localparam int MAX_AB  = (PHY_RST_CYC > STABLE_CYC) ? PHY_RST_CYC : STABLE_CYC;
  localparam int MAX_CD  = (STAGE_GAP > LOSS_CYC) ? STAGE_GAP : LOSS_CYC;
  localparam int CNT_MAX = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CW      = $clog2(CNT_MAX + 1);

  // Terminal values: a phase of N cycles ends on the cycle its counter holds N-1.
  localparam logic [TW-1:0] TIMER_LAST  = TW'(TIMEOUT_CYC - 1);
  localparam logic [TW-1:0] TIMER_SAT   = {TW{1'b1}};
  localparam logic [CW-1:0] PHY_LAST    = CW'(PHY_RST_CYC - 1);
  localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYC - 1);
  localparam logic [CW-1:0] GAP_LAST    = CW'(STAGE_GAP - 1);
  localparam logic [CW-1:0] LOSS_LAST   = CW'(LOSS_CYC - 1);
  localparam logic [CW-1:0] CNT_SAT     = {CW{1'b1}};
  localparam logic [3:0]    RETRY_LIMIT = 4'(MAX_RETRY);

  state_t        state_reg, state_next;
  logic [TW-1:0] timer_reg, timer_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [3:0]    retry_reg, retry_next;
  logic          phy_reg, phy_next;
  logic          mon_reg, mon_next;
  logic          mac_reg, mac_next;
  logic          core_reg, core_next;
  logic          link_reg, link_next;
  logic          fail_reg, fail_next;

  logic          link_ok;
  logic          in_window;
  logic [CW-1:0] cnt_inc;
  logic [TW-1:0] timer_inc;

  assign link_ok   = stat_rx & stat_tx;
  assign in_window = (state_reg == ST_WAIT_DONE) || (state_reg == ST_WAIT_STAT) ||
                     (state_reg == ST_STABLE);
  assign cnt_inc   = (cnt_reg == CNT_SAT) ? cnt_reg : cnt_reg + CW'(1);
  assign timer_inc = (timer_reg == TIMER_SAT) ? timer_reg : timer_reg + TW'(1);

  // Registers: state, counters and the decoded (registered) outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_PHY_RST;
      timer_reg <= '0;
      cnt_reg   <= '0;
      retry_reg <= '0;
      phy_reg   <= 1'b1;
      mon_reg   <= 1'b0;
      mac_reg   <= 1'b0;
      core_reg  <= 1'b0;
      link_reg  <= 1'b0;
      fail_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      timer_reg <= timer_next;
      cnt_reg   <= cnt_next;
      retry_reg <= retry_next;
      phy_reg   <= phy_next;
      mon_reg   <= mon_next;
      mac_reg   <= mac_next;
      core_reg  <= core_next;
      link_reg  <= link_next;
      fail_reg  <= fail_next;
    end
  end

  // Next-state and counter logic; timeout overrides forward moves, restart overrides all.
  always_comb begin
    state_next = state_reg;
    timer_next = timer_reg;
    cnt_next   = cnt_reg;
    retry_next = retry_reg;

    case (state_reg)
      ST_PHY_RST: begin
        if (cnt_reg == PHY_LAST) begin
          state_next = ST_WAIT_DONE;
          timer_next = '0;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_inc;
        end
      end
      ST_WAIT_DONE: begin
        timer_next = timer_inc;
        if (rst_done) begin
          state_next = ST_WAIT_STAT;
        end
      end
      ST_WAIT_STAT: begin
        timer_next = timer_inc;
        if (stat_good) begin
          state_next = ST_STABLE;
          cnt_next   = '0;
        end
      end
      ST_STABLE: begin
        timer_next = timer_inc;
        if (!link_ok) begin
          cnt_next = '0;
        end else if (cnt_reg == STABLE_LAST) begin
          state_next = ST_REL_MAC;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_inc;
        end
      end
      ST_REL_MAC: begin
        if (cnt_reg == GAP_LAST) begin
          state_next = ST_REL_CORE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_inc;
        end
      end
      ST_REL_CORE: begin
        state_next = ST_UP;
        cnt_next   = '0;
        retry_next = '0;
      end
      ST_UP: begin
        retry_next = '0;
        if (link_ok) begin
          cnt_next = '0;
        end else if (cnt_reg == LOSS_LAST) begin
          // Link loss re-sequences without consuming a retry.
          state_next = ST_PHY_RST;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_inc;
        end
      end
      ST_FAIL: begin
        state_next = ST_FAIL;
      end
      default: begin
        state_next = ST_PHY_RST;
        cnt_next   = '0;
        timer_next = '0;
      end
    endcase

    // The attempt window closes on its last cycle regardless of progress.
    if (in_window && (timer_reg == TIMER_LAST)) begin
      timer_next = '0;
      cnt_next   = '0;
      if (retry_reg == RETRY_LIMIT) begin
        state_next = ST_FAIL;
      end else begin
        state_next = ST_PHY_RST;
        retry_next = (retry_reg == 4'hF) ? retry_reg : retry_reg + 4'd1;
      end
    end

    if (restart) begin
      state_next = ST_PHY_RST;
      timer_next = '0;
      cnt_next   = '0;
      retry_next = '0;
    end
  end

  // Output decode from the next state so every output is a plain register.
  always_comb begin
    phy_next  = 1'b0;
    mon_next  = 1'b0;
    mac_next  = 1'b0;
    core_next = 1'b0;
    link_next = 1'b0;
    fail_next = 1'b0;
    case (state_next)
      ST_PHY_RST: begin
        phy_next = 1'b1;
      end
      ST_WAIT_DONE, ST_WAIT_STAT, ST_STABLE: begin
        mon_next = 1'b1;
      end
      ST_REL_MAC: begin
        mon_next = 1'b1;
        mac_next = 1'b1;
      end
      ST_REL_CORE, ST_UP: begin
        mon_next  = 1'b1;
        mac_next  = 1'b1;
        core_next = 1'b1;
        link_next = 1'b1;
      end
      ST_FAIL: begin
        fail_next = 1'b1;
      end
      default: begin
        phy_next = 1'b1;
      end
    endcase
  end

  assign phy_sys_reset = phy_reg;
  assign mon_reset_    = mon_reg;
  assign mac_reset_    = mac_reg;
  assign core_reset_   = core_reg;
  assign link_up       = link_reg;
  assign fail          = fail_reg;
  assign retry_cnt     = retry_reg;
  assign state         = state_reg;

endmodule

// File: tb/tb_rstctrl_linkseq.sv
// Directed bench for rstctrl_linkseq with small parameters. Cycle numbers are
// counted from the negedge at which reset is released (cycle 0); outputs are
// sampled and inputs driven on the falling edge.
module tb_rstctrl_linkseq;

  logic       clk = 1'b0;
  logic       reset;
  logic       restart;
  logic       rst_done;
  logic       stat_good;
  logic       stat_rx;
  logic       stat_tx;
  logic       phy_sys_reset;
  logic       mon_reset_;
  logic       mac_reset_;
  logic       core_reset_;
  logic       link_up;
  logic       fail;
  logic [3:0] retry_cnt;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  rstctrl_linkseq #(
    .PHY_RST_CYC(4),
    .TIMEOUT_CYC(100),
    .STABLE_CYC (8),
    .STAGE_GAP  (2),
    .LOSS_CYC   (4),
    .MAX_RETRY  (2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .restart      (restart),
    .rst_done     (rst_done),
    .stat_good    (stat_good),
    .stat_rx      (stat_rx),
    .stat_tx      (stat_tx),
    .phy_sys_reset(phy_sys_reset),
    .mon_reset_   (mon_reset_),
    .mac_reset_   (mac_reset_),
    .core_reset_  (core_reset_),
    .link_up      (link_up),
    .fail         (fail),
    .retry_cnt    (retry_cnt),
    .state        (state)
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end else begin
      $display("ok   %s cyc=%0d value=%0h", tag, cyc, obs);
    end
  endtask

  // Advance to the falling edge of absolute cycle c.
  task automatic goto(input int c);
    while (cyc < c) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  initial begin
    reset     = 1'b1;
    restart   = 1'b0;
    rst_done  = 1'b0;
    stat_good = 1'b0;
    stat_rx   = 1'b0;
    stat_tx   = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_state", 32'(state), 32'd0);
    check("rst_phy", 32'(phy_sys_reset), 32'd1);
    check("rst_mon", 32'(mon_reset_), 32'd0);
    check("rst_mac", 32'(mac_reset_), 32'd0);
    check("rst_core", 32'(core_reset_), 32'd0);
    check("rst_link", 32'(link_up), 32'd0);
    check("rst_fail", 32'(fail), 32'd0);
    check("rst_retry", 32'(retry_cnt), 32'd0);
    reset = 1'b0;
    cyc   = 0;

    // Nominal bring-up: PHY_RST 0-3, WAIT_DONE 4, STABLE from 16, MAC 24, core 26
    goto(3);
    check("nom_phy_c3", 32'(phy_sys_reset), 32'd1);
    goto(4);
    check("nom_phy_c4", 32'(phy_sys_reset), 32'd0);
    check("nom_mon_c4", 32'(mon_reset_), 32'd1);
    check("nom_state_c4", 32'(state), 32'd1);
    goto(10);
    rst_done = 1'b1;
    goto(11);
    check("nom_state_c11", 32'(state), 32'd2);
    goto(15);
    stat_good = 1'b1;
    stat_rx   = 1'b1;
    stat_tx   = 1'b1;
    goto(16);
    check("nom_state_c16", 32'(state), 32'd3);
    goto(23);
    check("nom_mac_c23", 32'(mac_reset_), 32'd0);
    goto(24);
    check("nom_mac_c24", 32'(mac_reset_), 32'd1);
    check("nom_core_c24", 32'(core_reset_), 32'd0);
    check("nom_state_c24", 32'(state), 32'd4);
    goto(25);
    check("nom_core_c25", 32'(core_reset_), 32'd0);
    goto(26);
    check("nom_core_c26", 32'(core_reset_), 32'd1);
    check("nom_link_c26", 32'(link_up), 32'd1);
    check("nom_state_c26", 32'(state), 32'd5);
    goto(27);
    check("nom_state_c27", 32'(state), 32'd6);
    check("nom_retry_c27", 32'(retry_cnt), 32'd0);

    // Link dip of 3 cycles keeps UP
    goto(30);
    stat_rx = 1'b0;
    goto(33);
    stat_rx = 1'b1;
    goto(36);
    check("dip3_state", 32'(state), 32'd6);
    check("dip3_link", 32'(link_up), 32'd1);

    // Link loss of 4 cycles: low at ends of 40..43, PHY_RST at 44
    goto(40);
    stat_rx = 1'b0;
    stat_tx = 1'b0;
    goto(43);
    check("loss_link_c43", 32'(link_up), 32'd1);
    goto(44);
    check("loss_link_c44", 32'(link_up), 32'd0);
    check("loss_mac_c44", 32'(mac_reset_), 32'd0);
    check("loss_phy_c44", 32'(phy_sys_reset), 32'd1);
    check("loss_state_c44", 32'(state), 32'd0);
    check("loss_retry_c44", 32'(retry_cnt), 32'd0);

    // Re-sequence with stability glitch: STABLE at 50, count 6 at 56 glitched
    goto(45);
    stat_rx = 1'b1;
    stat_tx = 1'b1;
    goto(50);
    check("glt_state_c50", 32'(state), 32'd3);
    goto(56);
    stat_rx = 1'b0;
    goto(57);
    stat_rx = 1'b1;
    goto(58);
    check("glt_mac_c58", 32'(mac_reset_), 32'd0);
    goto(64);
    check("glt_state_c64", 32'(state), 32'd3);
    goto(65);
    check("glt_mac_c65", 32'(mac_reset_), 32'd1);
    check("glt_state_c65", 32'(state), 32'd4);

    // Reset in REL_MAC
    reset = 1'b1;
    goto(66);
    check("mrst_mac", 32'(mac_reset_), 32'd0);
    check("mrst_state", 32'(state), 32'd0);
    check("mrst_retry", 32'(retry_cnt), 32'd0);
    check("mrst_phy", 32'(phy_sys_reset), 32'd1);
    reset     = 1'b0;
    rst_done  = 1'b0;
    stat_good = 1'b0;
    stat_rx   = 1'b0;
    stat_tx   = 1'b0;

    // Timeout retries: WAIT_DONE 70-169, 174-273, 278-377; FAIL at 378
    goto(169);
    check("to1_state_c169", 32'(state), 32'd1);
    check("to1_retry_c169", 32'(retry_cnt), 32'd0);
    goto(170);
    check("to1_phy_c170", 32'(phy_sys_reset), 32'd1);
    check("to1_retry_c170", 32'(retry_cnt), 32'd1);
    goto(273);
    check("to2_phy_c273", 32'(phy_sys_reset), 32'd0);
    goto(274);
    check("to2_phy_c274", 32'(phy_sys_reset), 32'd1);
    check("to2_retry_c274", 32'(retry_cnt), 32'd2);
    goto(377);
    check("to3_state_c377", 32'(state), 32'd1);
    rst_done = 1'b1;  // same-cycle forward move must lose to the timeout
    goto(378);
    check("to3_state_c378", 32'(state), 32'd7);
    check("to3_fail_c378", 32'(fail), 32'd1);
    check("to3_mon_c378", 32'(mon_reset_), 32'd0);
    check("to3_phy_c378", 32'(phy_sys_reset), 32'd0);
    check("to3_retry_c378", 32'(retry_cnt), 32'd2);
    goto(382);
    check("fail_hold_c382", 32'(state), 32'd7);

    // Restart from FAIL, then nominal bring-up: STABLE 389, MAC 397, UP 400
    restart = 1'b1;
    goto(383);
    restart = 1'b0;
    check("rs_state_c383", 32'(state), 32'd0);
    check("rs_fail_c383", 32'(fail), 32'd0);
    check("rs_retry_c383", 32'(retry_cnt), 32'd0);
    check("rs_phy_c383", 32'(phy_sys_reset), 32'd1);
    stat_good = 1'b1;
    stat_rx   = 1'b1;
    stat_tx   = 1'b1;
    goto(389);
    check("rs_state_c389", 32'(state), 32'd3);
    goto(397);
    check("rs_mac_c397", 32'(mac_reset_), 32'd1);
    goto(400);
    check("rs_state_c400", 32'(state), 32'd6);
    check("rs_link_c400", 32'(link_up), 32'd1);
    check("rs_core_c400", 32'(core_reset_), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
